// File: rtl/virtual_tile_mc_pkg.sv
// Shared types and widths for the virtual tile multi-channel join block.
package vtile_pkg;
    localparam int STATE_W = 2;
    localparam int CNT_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/virtual_tile_mc_if.sv
// Channel/output handshake bundle for virtual_tile_mc; slave = tile side, master = driver side.
interface vtile_if import vtile_pkg::*; #(
    parameter int DW     = 32,
    parameter int NUM_IN = 3
) ();
    logic [NUM_IN*DW-1:0] in_data_i;
    logic [NUM_IN-1:0]    in_valid_i;
    logic [NUM_IN-1:0]    in_ready_o;
    logic [DW-1:0]        out_data_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [STATE_W-1:0]   state_o;
    logic [CNT_W-1:0]     fire_cnt_o;
    logic                 stall_o;

    modport slave (
        input  in_data_i, in_valid_i, out_ready_i,
        output in_ready_o, out_data_o, out_valid_o, state_o, fire_cnt_o, stall_o
    );

    modport master (
        output in_data_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_data_o, out_valid_o, state_o, fire_cnt_o, stall_o
    );
endinterface

// File: rtl/virtual_tile_mc_network_fifo.sv
// Receive buffer with occupancy counter; FWFT=1 presents the head flit combinationally.
module network_fifo #(
    parameter int W         = 32,
    parameter int DEPTH_LOG = 2,
    parameter bit FWFT      = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    output logic         full_o,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         empty_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG;

    logic [W-1:0]         mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 do_wr, do_rd;

    // Full is derived from registered occupancy only, so a same-cycle pop never frees a slot.
    assign full_o  = (count_q == (DEPTH_LOG+1)'(DEPTH));
    assign empty_o = (count_q == '0);

    always_comb begin
        do_wr    = wr_en_i & ~full_o;
        do_rd    = rd_en_i & ~empty_o;
        wr_ptr_d = wr_ptr_q + DEPTH_LOG'(do_wr);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG'(do_rd);
        count_d  = count_q + (DEPTH_LOG+1)'(do_wr) - (DEPTH_LOG+1)'(do_rd);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data_i;
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data_o = mem[rd_ptr_q];
        end else begin : g_std
            logic [W-1:0] rd_data_q;
            always_ff @(posedge clk_i) begin
                if (rst_i)      rd_data_q <= '0;
                else if (do_rd) rd_data_q <= mem[rd_ptr_q];
            end
            assign rd_data_o = rd_data_q;
        end
    endgenerate
endmodule

// File: rtl/virtual_tile_mc.sv
// Joins all enabled input channels into one XOR-combined output flit, with run/done FSM and stall detect.
// Optional macro VTILE_TRACE_EN prints state transitions and stall onset with tile coordinates.
module virtual_tile_mc import vtile_pkg::*; #(
    parameter int                DW             = 32,
    parameter int                NUM_IN         = 3,
    parameter logic [NUM_IN-1:0] IN_MASK        = 3'b111,
    parameter int                RBUF_DEPTH_LOG = 2,
    parameter int                PKT_COUNT      = 1000,
    parameter int                STALL_LIMIT    = 4096,
    parameter int                X              = 0,
    parameter int                Y              = 0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    vtile_if.slave bus
);
    localparam int IDLE_W = $clog2(STALL_LIMIT + 1);

    logic [NUM_IN-1:0]         ch_empty, ch_full;
    logic [NUM_IN-1:0][DW-1:0] head;
    logic                      join_valid, fire;
    logic [DW-1:0]             xor_data;

    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  fire_cnt_q, fire_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              stall_q, stall_d;

    // Disabled channels look permanently non-empty with a zero head, so they drop out of join and XOR.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ch
            if (IN_MASK[gi]) begin : g_en
                network_fifo #(
                    .W(DW), .DEPTH_LOG(RBUF_DEPTH_LOG), .FWFT(1'b1)
                ) u_rbuf (
                    .clk_i    (clk_i),
                    .rst_i    (rst_i),
                    .wr_en_i  (bus.in_valid_i[gi]),
                    .wr_data_i(bus.in_data_i[gi*DW +: DW]),
                    .full_o   (ch_full[gi]),
                    .rd_en_i  (fire),
                    .rd_data_o(head[gi]),
                    .empty_o  (ch_empty[gi])
                );
            end else begin : g_dis
                logic unused_in;
                assign unused_in    = ^{bus.in_valid_i[gi], bus.in_data_i[gi*DW +: DW]};
                assign ch_full[gi]  = 1'b1;
                assign ch_empty[gi] = 1'b0;
                assign head[gi]     = '0;
            end
        end
    endgenerate

    always_comb begin
        join_valid = ~|ch_empty;
        fire       = join_valid & (~out_valid_q | bus.out_ready_i);
        xor_data   = '0;
        for (int k = 0; k < NUM_IN; k++) xor_data = xor_data ^ head[k];

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = xor_data;
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end

        fire_cnt_d = fire_cnt_q;
        if (fire && (fire_cnt_q < CNT_W'(PKT_COUNT))) fire_cnt_d = fire_cnt_q + 1'b1;

        state_d = state_q;
        case (state_q)
            IDLE:    if (fire) state_d = (fire_cnt_d == CNT_W'(PKT_COUNT)) ? DONE : RUN;
            RUN:     if (fire && (fire_cnt_d == CNT_W'(PKT_COUNT))) state_d = DONE;
            default: state_d = state_q;
        endcase

        idle_d = '0;
        if ((state_q == RUN) && !fire)
            idle_d = (idle_q == IDLE_W'(STALL_LIMIT)) ? idle_q : idle_q + 1'b1;
        stall_d = (state_d == RUN) && (idle_d == IDLE_W'(STALL_LIMIT));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            state_q     <= IDLE;
            fire_cnt_q  <= '0;
            idle_q      <= '0;
            stall_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            state_q     <= state_d;
            fire_cnt_q  <= fire_cnt_d;
            idle_q      <= idle_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.in_ready_o  = ~ch_full;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.state_o     = state_q;
    assign bus.fire_cnt_o  = fire_cnt_q;
    assign bus.stall_o     = stall_q;

`ifdef VTILE_TRACE_EN
    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == IDLE && state_d == RUN)
                $display("%0t vtile(%0d,%0d) IDLE->RUN", $time, X, Y);
            if (state_q == RUN && state_d == DONE)
                $display("%0t vtile(%0d,%0d) RUN->DONE", $time, X, Y);
            if (!stall_q && stall_d)
                $display("%0t vtile(%0d,%0d) stall", $time, X, Y);
        end
    end
`else
    localparam int unused_xy = X + Y;
`endif
endmodule

// File: tb/tb_virtual_tile_mc.sv
// Randomised bench for virtual_tile_mc against a queue-based reference model, plus a masked-channel instance.
module tb_virtual_tile_mc;
    localparam int PKT   = 8;
    localparam int STALL = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    vtile_if #(.DW(32), .NUM_IN(3)) bus_a ();
    vtile_if #(.DW(32), .NUM_IN(3)) bus_b ();

    virtual_tile_mc #(
        .DW(32), .NUM_IN(3), .IN_MASK(3'b111), .RBUF_DEPTH_LOG(2),
        .PKT_COUNT(PKT), .STALL_LIMIT(STALL), .X(1), .Y(2)
    ) u_dut_a (.clk_i(clk), .rst_i(rst_a), .bus(bus_a.slave));

    virtual_tile_mc #(
        .DW(32), .NUM_IN(3), .IN_MASK(3'b101), .RBUF_DEPTH_LOG(2)
    ) u_dut_b (.clk_i(clk), .rst_i(rst_b), .bus(bus_b.slave));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-channel flit queues, one output slot, fire counter and idle counter.
    logic [31:0] mq [3][$];
    logic [31:0] m_data;
    bit          m_valid;
    int          m_cnt, m_idle;
    int          acc_cnt [3];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (m_cnt == 0)   return 0;
        if (m_cnt >= PKT) return 2;
        return 1;
    endfunction

    task automatic cycle(input logic [2:0] v, input logic [95:0] d, input bit ordy, input bit rst);
        bit          fire, pre_run;
        logic [2:0]  rdy, exp_rdy;
        logic [31:0] x;
        bus_a.in_valid_i  = v;
        bus_a.in_data_i   = d;
        bus_a.out_ready_i = ordy;
        rst_a             = rst;
        if (rst) begin
            for (int k = 0; k < 3; k++) mq[k].delete();
            m_data = '0; m_valid = 0; m_cnt = 0; m_idle = 0;
        end else begin
            for (int k = 0; k < 3; k++) rdy[k] = (mq[k].size() < DEPTH);
            fire = (mq[0].size() > 0) && (mq[1].size() > 0) && (mq[2].size() > 0)
                   && (!m_valid || ordy);
            pre_run = (m_cnt > 0) && (m_cnt < PKT);
            if (fire) begin
                x = '0;
                for (int k = 0; k < 3; k++) x ^= mq[k].pop_front();
                m_data  = x;
                m_valid = 1;
                if (m_cnt < PKT) m_cnt++;
            end else if (ordy) begin
                m_valid = 0;
            end
            if (!pre_run || fire) m_idle = 0;
            else if (m_idle < STALL) m_idle++;
            for (int k = 0; k < 3; k++)
                if (v[k] && rdy[k]) begin
                    mq[k].push_back(d[k*32 +: 32]);
                    acc_cnt[k]++;
                end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) exp_rdy[k] = (mq[k].size() < DEPTH);
        chk("out_valid", 64'(bus_a.out_valid_o), 64'(m_valid));
        chk("out_data",  64'(bus_a.out_data_o),  64'(m_data));
        chk("in_ready",  64'(bus_a.in_ready_o),  64'(exp_rdy));
        chk("state",     64'(bus_a.state_o),     64'(exp_state()));
        chk("fire_cnt",  64'(bus_a.fire_cnt_o),  64'(m_cnt));
        chk("stall",     64'(bus_a.stall_o),
            64'((m_cnt > 0) && (m_cnt < PKT) && (m_idle == STALL)));
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [2:0] v;
        rst_a = 1'b1;
        bus_a.in_valid_i = '0; bus_a.in_data_i = '0; bus_a.out_ready_i = 1'b0;

        // Masked instance: channel 1 disabled, never ready, excluded from the XOR.
        rst_b = 1'b1;
        bus_b.in_valid_i = '0; bus_b.in_data_i = '0; bus_b.out_ready_i = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(posedge clk); #1;
        chk("b_ready_mask", 64'(bus_b.in_ready_o), 64'(3'b101));
        bus_b.in_valid_i = 3'b111;
        bus_b.in_data_i  = {32'd3, 32'hFF, 32'd5};
        #1;
        chk("b_ready_ch1", 64'(bus_b.in_ready_o[1]), 64'd0);
        @(posedge clk); #1;
        bus_b.in_valid_i = '0;
        @(posedge clk); #1;
        chk("b_out_valid", 64'(bus_b.out_valid_o), 64'd1);
        chk("b_out_data",  64'(bus_b.out_data_o),  64'd6);

        // Reset, then a single flit per channel: XOR appears two edges later.
        cycle('0, '0, 1'b1, 1'b1);
        cycle('0, '0, 1'b1, 1'b1);
        cycle('0, '0, 1'b1, 1'b0);
        chk("rst_ready", 64'(bus_a.in_ready_o), 64'(3'b111));
        cycle(3'b111, {32'd4, 32'd2, 32'd1}, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        chk("lat_data",  64'(bus_a.out_data_o), 64'd7);
        chk("lat_state", 64'(bus_a.state_o),    64'd1);

        // Starve channel 2 until the stall flag rises, then let one flit through.
        for (int i = 0; i < 20; i++) cycle(3'b011, rnd96(), 1'b1, 1'b0);
        chk("stall_set", 64'(bus_a.stall_o), 64'd1);
        cycle(3'b100, {32'd9, 64'd0}, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        chk("stall_clr", 64'(bus_a.stall_o), 64'd0);

        // Backpressure: 4 buffered plus 1 in the output register per channel.
        cycle('0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) acc_cnt[k] = 0;
        for (int i = 0; i < 10; i++) cycle(3'b111, rnd96(), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) chk("bp_accepted", 64'(acc_cnt[k]), 64'd5);
        chk("bp_ready_low", 64'(bus_a.in_ready_o), 64'd0);
        for (int i = 0; i < 8; i++) cycle('0, '0, 1'b1, 1'b0);
        chk("bp_drained", 64'(bus_a.fire_cnt_o), 64'd5);

        // Continuous traffic past PKT_COUNT: DONE, counter holds, data keeps flowing.
        for (int i = 0; i < 6; i++) cycle(3'b111, rnd96(), 1'b1, 1'b0);
        chk("done_state", 64'(bus_a.state_o),     64'd2);
        chk("done_cnt",   64'(bus_a.fire_cnt_o),  64'(PKT));
        chk("done_flow",  64'(bus_a.out_valid_o), 64'd1);

        // Single-cycle reset with full buffers.
        for (int i = 0; i < 8; i++) cycle(3'b111, rnd96(), 1'b0, 1'b0);
        cycle(3'b111, rnd96(), 1'b0, 1'b1);
        chk("mid_rst_valid", 64'(bus_a.out_valid_o), 64'd0);
        chk("mid_rst_state", 64'(bus_a.state_o),     64'd0);
        chk("mid_rst_cnt",   64'(bus_a.fire_cnt_o),  64'd0);

        // Random traffic with starvation windows and occasional resets.
        for (int i = 0; i < 600; i++) begin
            v = 3'($urandom());
            if ((i % 100) >= 50 && (i % 100) < 80) v[2] = 1'b0;
            cycle(v, rnd96(), $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/virtual_tile_mc.md
VIRTUAL_TILE_MC -- requirements
Module: virtual_tile_mc

Interface
REQ-001 Parameter DW, default 32: flit data width.
REQ-002 Parameter NUM_IN, default 3, range 1..4: input channel count; channel 0 is cast.
REQ-003 Parameter IN_MASK, default 'b111: channel enable bits; bit 0 SHALL be 1.
REQ-004 Parameter RBUF_DEPTH_LOG, default 2: per-channel receive buffer depth is 2**RBUF_DEPTH_LOG.
REQ-005 Parameter PKT_COUNT, default 1000: fires to completion.
REQ-006 Parameter STALL_LIMIT, default 4096: idle cycles in RUN before stall flag.
REQ-007 Parameters X, Y, default 0: tile coordinates, trace only.
REQ-008 clk_i  in  1  single clock; all logic on its rising edge.
REQ-009 rst_i  in  1  reset, synchronous, active-high.
REQ-010 in_data_i  in  NUM_IN*DW  channel data, channel k at bits [k*DW +: DW].
REQ-011 in_valid_i  in  NUM_IN  per-channel valid.
REQ-012 in_ready_o  out  NUM_IN  per-channel ready.
REQ-013 out_data_o  out  DW  output data.
REQ-014 out_valid_o  out  1  output valid.
REQ-015 out_ready_i  in  1  output ready.
REQ-016 state_o  out  2  FSM state.
REQ-017 fire_cnt_o  out  32  fire count, saturates at PKT_COUNT.
REQ-018 stall_o  out  1  no-progress flag.

Function
REQ-019 Each enabled channel SHALL have a FWFT receive buffer; write = in_valid_i[k] & in_ready_o[k]; in_ready_o[k] = ~full.
REQ-020 A disabled channel SHALL drive in_ready_o[k]=0, have no buffer, and be excluded from join and data.
REQ-021 join_valid = AND of ~empty over enabled channels.
REQ-022 Output is a one-entry register; fire = join_valid & (~out_valid_o | out_ready_i).
REQ-023 On fire: pop one flit from every enabled buffer; load out_data_o = XOR of enabled head flits; set out_valid_o.
REQ-024 out_valid_o SHALL clear when out_ready_i is high and there is no fire that cycle.
REQ-025 Latency: flits written at cycle t to all-empty buffers with output free SHALL give out_valid_o at t+2.
REQ-026 Throughput: one fire per cycle with continuous input and out_ready_i held high.
REQ-027 Full buffer with a simultaneous pop SHALL keep in_ready_o low that cycle (registered full).
REQ-028 FSM states: IDLE=0, RUN=1, DONE=2.
REQ-029 IDLE->RUN on the first fire.
REQ-030 RUN->DONE on the fire that makes fire_cnt_o equal PKT_COUNT.
REQ-031 DONE is absorbing until reset; data forwarding continues in DONE.
REQ-032 fire_cnt_o increments on each fire and holds at PKT_COUNT.
REQ-033 Idle counter: in RUN it increments each cycle without a fire and clears on fire.
REQ-034 stall_o SHALL set when the idle counter reaches STALL_LIMIT, stay set until the next fire, and be 0 outside RUN.
REQ-035 The idle counter SHALL saturate at STALL_LIMIT.

Reset
REQ-036 While rst_i is high: buffers empty; out_valid_o=0; out_data_o=0; state_o=IDLE; fire_cnt_o=0; stall_o=0; idle counter=0.
REQ-037 in_ready_o SHALL equal IN_MASK from the cycle after reset deasserts.
REQ-038 Reset asserted mid-stream SHALL discard all buffered and registered flits at the next edge.

Configuration
REQ-039 Macro VTILE_TRACE_EN defined: $display with time and (X,Y) on IDLE->RUN, RUN->DONE, and the rising edge of stall_o.
REQ-040 Macro VTILE_TRACE_EN undefined: no simulation output; port behaviour identical.

Structure
REQ-041 Package vtile_pkg SHALL hold the state enum (IDLE/RUN/DONE), the 2-bit state width, and the fire counter width constant 32.
REQ-042 Receive buffers SHALL be instances of the existing network_fifo with FWFT=1, one per enabled channel, generated per channel.

Verification
REQ-043 NUM_IN=3, IN_MASK=111: one flit per channel (1, 2, 4), out_ready_i=1 -> out_data_o=7 two cycles later; fire_cnt_o=1; state_o=RUN.
REQ-044 IN_MASK=101: drive channel 1 valid -> in_ready_o[1]=0; channels 0 and 2 with 5 and 3 -> out_data_o=6.
REQ-045 out_ready_i=0, stream all channels, depth 4 -> exactly 5 flits accepted per channel (4 buffered + 1 in output register); in_ready_o low; no loss after release.
REQ-046 PKT_COUNT=8, continuous traffic -> state_o=DONE after 8th fire; fire_cnt_o holds 8; output keeps flowing.
REQ-047 STALL_LIMIT=16, after one fire starve channel 2 -> stall_o high 16 cycles later; one further fire -> stall_o low.
REQ-048 rst_i asserted for 1 cycle with full buffers -> all outputs at reset values at the next edge; subsequent traffic restarts from IDLE.
